// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU bus and a DMA requester.
// Optional feature macro MEM_ARB_LOCK_EN adds dma_lock for uninterrupted DMA bursts.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              dma_lock,
`endif
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int unsigned LAT_W    = 2;
  localparam int unsigned STREAK_W = 4;
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(RD_LAT - 1);
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_LAT    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                owner_dma_q, owner_dma_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic                busy_q, busy_d;
  logic                grant_dma_c, grant_cpu_c, lock_win_c;

  // owner_dma_q doubles as the "last grant" record used by the lock
`ifdef MEM_ARB_LOCK_EN
  assign lock_win_c = dma_lock && owner_dma_q;
`else
  assign lock_win_c = 1'b0;
`endif

  // Next-state, arbitration and registered-output logic
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    owner_dma_d = owner_dma_q;
    lat_cnt_d   = lat_cnt_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    grant_dma_c = 1'b0;
    grant_cpu_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_dma_c = dma_req && (!cpu_req || (streak_q == STREAK_LIM) || lock_win_c);
        grant_cpu_c = cpu_req && !grant_dma_c;
        if (grant_dma_c) begin
          state_d     = S_ACCESS;
          owner_dma_d = 1'b1;
          ram_we_d    = dma_we;
          ram_addr_d  = dma_addr;
          ram_din_d   = dma_wdata;
          streak_d    = '0;
        end else if (grant_cpu_c) begin
          state_d     = S_ACCESS;
          owner_dma_d = 1'b0;
          ram_we_d    = cpu_we;
          ram_addr_d  = cpu_addr;
          ram_din_d   = cpu_wdata;
          if (!dma_req) streak_d = '0;
          else if (streak_q != STREAK_LIM) streak_d = streak_q + STREAK_W'(1);
        end else begin
          streak_d = '0;
        end
`ifdef MEM_ARB_LOCK_EN
        if (dma_lock) streak_d = '0;
`endif
      end
      S_ACCESS: begin
        ram_we_d = 1'b0;
        if (ram_we_q) begin
          state_d   = S_DONE;
          cpu_ack_d = !owner_dma_q;
          dma_ack_d = owner_dma_q;
        end else begin
          state_d   = S_LAT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      S_LAT: begin
        if (lat_cnt_q == '0) begin
          state_d   = S_DONE;
          cpu_ack_d = !owner_dma_q;
          dma_ack_d = owner_dma_q;
          if (owner_dma_q) dma_rdata_d = ram_dout;
          else             cpu_rdata_d = ram_dout;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      owner_dma_q <= 1'b0;
      lat_cnt_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      owner_dma_q <= owner_dma_d;
      lat_cnt_q   <= lat_cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign busy      = busy_q;

endmodule
